mem_slice: RTL and testbench
============================

MEM_SLICE -- requirements
Module: mem_slice

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 8, the maximum number of memory wait cycles before a forced completion.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; synchronous, active-low.
REQ-004 The block SHALL have inputs from the EX stage: valid_in 1, WB_in 2, M_in 3, addr_in 16, data_in 16, result_in 16, flags_in 3 {zr,neg,ov}, PCbranch_in 16, bcond_in 3, rd_in 4.
REQ-005 The block SHALL have memory ports mem_addr out 16, mem_wdata out 16, mem_re out 1, mem_we out 1, mem_rdy in 1, mem_rdata in 16.
REQ-006 The block SHALL have pipeline control outputs stall 1 (freeze IF/ID/EX), PCsrc 1 (take branch), PCbranch 16, flush 1 (squash IF/ID/EX).
REQ-007 The block SHALL have MEM/WB outputs valid_out 1, WB 2, rdata 16, result 16, rd 4, and mem_err 1 (sticky timeout flag).

Function
REQ-008 M encoding SHALL be M[0] MemRead, M[1] MemWrite, M[2] Branch; WB SHALL pass through unmodified.
REQ-009 The EX/MEM register (all REQ-004 inputs) SHALL load on every rising edge where stall=0; it SHALL hold while stall=1.
REQ-010 FSM states SHALL be IDLE and WAIT; IDLE->WAIT when the registered instruction is valid, has M[0] or M[1] set, and mem_rdy=0; WAIT->IDLE on mem_rdy=1 or timeout.
REQ-011 mem_re SHALL equal valid_q & M_q[0] & ~M_q[1]; mem_we SHALL equal valid_q & M_q[1]; M[0] and M[1] both set SHALL perform a store only.
REQ-012 mem_addr SHALL equal addr_q; mem_wdata SHALL equal data_q; both SHALL be held stable while stall=1.
REQ-013 stall SHALL equal valid_q & (M_q[0] | M_q[1]) & ~mem_rdy & ~timeout, combinationally, in both IDLE and WAIT.
REQ-014 A 4-bit wait counter SHALL clear in IDLE, increment each WAIT cycle; timeout SHALL assert when counter = TIMEOUT-1 in WAIT.
REQ-015 On timeout the instruction SHALL complete with rdata=0x0000, mem_err SHALL set and stay set until reset.
REQ-016 Branch taken SHALL be valid_q & M_q[2] & cond; cond from bcond_q and flags_q: 000 ~Z, 001 Z, 010 ~Z&~N, 011 N, 100 Z|~N, 101 Z|N, 110 V, 111 1.
REQ-017 PCsrc and flush SHALL equal branch taken combinationally; PCbranch SHALL equal PCbranch_q.
REQ-018 A branch with M[0] or M[1] set SHALL resolve without stalling and issue no memory access.
REQ-019 The MEM/WB register SHALL load on each edge where stall=0: valid_out<=valid_q, WB<=WB_q, result<=result_q, rd<=rd_q, rdata<=mem_rdata (load) or 0 (timeout/non-load).
REQ-020 While stall=1, valid_out SHALL be loaded 0 (bubble) and WB<=00; other MEM/WB fields hold.
REQ-021 valid_q=0 SHALL suppress mem_re, mem_we, stall, PCsrc, flush, and produce valid_out=0 next edge.
REQ-022 Non-memory, non-branch instructions SHALL have one-cycle latency EX/MEM to MEM/WB.

Reset
REQ-023 With rst=0 at a rising edge, all EX/MEM and MEM/WB registers SHALL clear to 0, FSM to IDLE, counter to 0, mem_err to 0.
REQ-024 Reset asserted during WAIT SHALL abandon the access; mem_re/mem_we SHALL be 0 the cycle after the reset edge.
REQ-025 During and after reset, stall, PCsrc, flush, valid_out SHALL be 0 until a valid instruction is captured.

Verification
REQ-026 ADD result 0x1234, rd=3, WB=01 -> next edge valid_out=1, result=0x1234, rd=3, stall never 1.
REQ-027 Load addr 0x0040, mem_rdy low 2 cycles then high with 0xBEEF -> stall=1 exactly 2 cycles, mem_addr=0x0040 stable, rdata=0xBEEF, two bubbles before it.
REQ-028 Store addr 0x0010 data 0xA5A5, mem_rdy=1 immediately -> mem_we=1 one cycle, mem_wdata=0xA5A5, no stall.
REQ-029 Branch bcond=001 with flags Z=1 -> PCsrc=flush=1, PCbranch=PCbranch_in; same with Z=0 -> PCsrc=0; bcond=111 -> always taken.
REQ-030 Load with mem_rdy held 0, TIMEOUT=8 -> stall for 7 cycles, then rdata=0, mem_err=1 persisting until rst=0.
REQ-031 rst=0 driven during WAIT -> next cycle mem_re=0, stall=0, all outputs 0, mem_err=0.

Source files
------------

// File: rtl/mem_slice.sv
// MEM stage of a 5-stage pipeline: EX/MEM register, memory handshake with a bounded
// wait, branch resolution, and the MEM/WB register.
module mem_slice #(
    parameter int TIMEOUT = 8  // usable range 2..16: the wait counter is 4 bits wide
) (
    input  logic        clk,
    input  logic        rst,
    // EX stage
    input  logic        valid_in,
    input  logic [1:0]  WB_in,
    input  logic [2:0]  M_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] data_in,
    input  logic [15:0] result_in,
    input  logic [2:0]  flags_in,
    input  logic [15:0] PCbranch_in,
    input  logic [2:0]  bcond_in,
    input  logic [3:0]  rd_in,
    // memory
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic        mem_rdy,
    input  logic [15:0] mem_rdata,
    // pipeline control
    output logic        stall,
    output logic        PCsrc,
    output logic [15:0] PCbranch,
    output logic        flush,
    // MEM/WB
    output logic        valid_out,
    output logic [1:0]  WB,
    output logic [15:0] rdata,
    output logic [15:0] result,
    output logic [3:0]  rd,
    output logic        mem_err
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [3:0] TIMEOUT_LAST = 4'(TIMEOUT - 1);

    // EX/MEM register
    logic        valid_q,    valid_d;
    logic [1:0]  wb_q,       wb_d;
    logic [2:0]  m_q,        m_d;
    logic [15:0] addr_q,     addr_d;
    logic [15:0] data_q,     data_d;
    logic [15:0] result_q,   result_d;
    logic [2:0]  flags_q,    flags_d;
    logic [15:0] pcbranch_q, pcbranch_d;
    logic [2:0]  bcond_q,    bcond_d;
    logic [3:0]  rd_q,       rd_d;

    // control state
    state_t      state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic        mem_err_q,  mem_err_d;

    // MEM/WB register
    logic        valid_out_q, valid_out_d;
    logic [1:0]  wb_out_q,    wb_out_d;
    logic [15:0] rdata_q,     rdata_d;
    logic [15:0] result_out_q, result_out_d;
    logic [3:0]  rd_out_q,    rd_out_d;

    logic mem_op;
    logic is_load;
    logic timeout;
    logic cond;
    logic zr, neg, ov;

    assign {zr, neg, ov} = flags_q;

    // A branch never touches memory, even with M[0]/M[1] set.
    assign mem_op  = valid_q & ~m_q[2] & (m_q[0] | m_q[1]);
    assign is_load = mem_op & m_q[0] & ~m_q[1];
    assign timeout = (state_q == ST_WAIT) && (cnt_q == TIMEOUT_LAST);

    assign mem_re    = is_load;
    assign mem_we    = mem_op & m_q[1];
    assign mem_addr  = addr_q;
    assign mem_wdata = data_q;
    assign stall     = mem_op & ~mem_rdy & ~timeout;

    always_comb begin
        unique case (bcond_q)
            3'b000:  cond = ~zr;
            3'b001:  cond = zr;
            3'b010:  cond = ~zr & ~neg;
            3'b011:  cond = neg;
            3'b100:  cond = zr | ~neg;
            3'b101:  cond = zr | neg;
            3'b110:  cond = ov;
            default: cond = 1'b1;
        endcase
    end

    assign PCsrc    = valid_q & m_q[2] & cond;
    assign flush    = PCsrc;
    assign PCbranch = pcbranch_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch.
        state_d   = state_q;
        cnt_d     = 4'd0;
        mem_err_d = mem_err_q | timeout;

        // The counter holds the number of cycles already stalled, so it is zero in IDLE.
        if (stall) begin
            cnt_d = cnt_q + 4'd1;
        end

        unique case (state_q)
            ST_IDLE: if (stall) state_d = ST_WAIT;
            ST_WAIT: if (mem_rdy || timeout) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_d    = valid_q;
        wb_d       = wb_q;
        m_d        = m_q;
        addr_d     = addr_q;
        data_d     = data_q;
        result_d   = result_q;
        flags_d    = flags_q;
        pcbranch_d = pcbranch_q;
        bcond_d    = bcond_q;
        rd_d       = rd_q;

        valid_out_d  = 1'b0;
        wb_out_d     = 2'b00;
        rdata_d      = rdata_q;
        result_out_d = result_out_q;
        rd_out_d     = rd_out_q;

        if (!stall) begin
            valid_d    = valid_in;
            wb_d       = WB_in;
            m_d        = M_in;
            addr_d     = addr_in;
            data_d     = data_in;
            result_d   = result_in;
            flags_d    = flags_in;
            pcbranch_d = PCbranch_in;
            bcond_d    = bcond_in;
            rd_d       = rd_in;

            valid_out_d  = valid_q;
            wb_out_d     = wb_q;
            result_out_d = result_q;
            rd_out_d     = rd_q;
            rdata_d      = (is_load && !timeout) ? mem_rdata : 16'h0000;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            valid_q      <= 1'b0;
            wb_q         <= 2'b00;
            m_q          <= 3'b000;
            addr_q       <= 16'h0000;
            data_q       <= 16'h0000;
            result_q     <= 16'h0000;
            flags_q      <= 3'b000;
            pcbranch_q   <= 16'h0000;
            bcond_q      <= 3'b000;
            rd_q         <= 4'h0;
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            mem_err_q    <= 1'b0;
            valid_out_q  <= 1'b0;
            wb_out_q     <= 2'b00;
            rdata_q      <= 16'h0000;
            result_out_q <= 16'h0000;
            rd_out_q     <= 4'h0;
        end else begin
            valid_q      <= valid_d;
            wb_q         <= wb_d;
            m_q          <= m_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            pcbranch_q   <= pcbranch_d;
            bcond_q      <= bcond_d;
            rd_q         <= rd_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            mem_err_q    <= mem_err_d;
            valid_out_q  <= valid_out_d;
            wb_out_q     <= wb_out_d;
            rdata_q      <= rdata_d;
            result_out_q <= result_out_d;
            rd_out_q     <= rd_out_d;
        end
    end

    assign valid_out = valid_out_q;
    assign WB        = wb_out_q;
    assign rdata     = rdata_q;
    assign result    = result_out_q;
    assign rd        = rd_out_q;
    assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_slice.sv
// Directed self-checking bench for mem_slice: inputs change on the falling edge,
// outputs are sampled 1 time unit after the falling edge.
module tb_mem_slice;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [1:0]  WB_in;
    logic [2:0]  M_in;
    logic [15:0] addr_in, data_in, result_in, PCbranch_in;
    logic [2:0]  flags_in, bcond_in;
    logic [3:0]  rd_in;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we, mem_rdy;
    logic        stall, PCsrc, flush;
    logic [15:0] PCbranch;
    logic        valid_out;
    logic [1:0]  WB;
    logic [15:0] rdata, result;
    logic [3:0]  rd;
    logic        mem_err;

    int checks = 0;
    int errors = 0;

    mem_slice #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .WB_in(WB_in), .M_in(M_in), .addr_in(addr_in),
        .data_in(data_in), .result_in(result_in), .flags_in(flags_in),
        .PCbranch_in(PCbranch_in), .bcond_in(bcond_in), .rd_in(rd_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .stall(stall), .PCsrc(PCsrc), .PCbranch(PCbranch), .flush(flush),
        .valid_out(valid_out), .WB(WB), .rdata(rdata), .result(result), .rd(rd),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

    task automatic drive(input logic v, input logic [1:0] wb, input logic [2:0] m,
                         input logic [15:0] addr, input logic [15:0] data,
                         input logic [15:0] res, input logic [2:0] flags,
                         input logic [15:0] pcb, input logic [2:0] bc, input logic [3:0] rdv);
        valid_in = v; WB_in = wb; M_in = m; addr_in = addr; data_in = data;
        result_in = res; flags_in = flags; PCbranch_in = pcb; bcond_in = bc; rd_in = rdv;
    endtask

    task automatic nop();
        drive(1'b0, 2'b00, 3'b000, 16'hFFFF, 16'hFFFF, 16'h0000, 3'b000, 16'h0000, 3'b000, 4'h0);
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_rdy = 1'b0; mem_rdata = 16'h0000;
        drive(1'b1, 2'b01, 3'b001, 16'h0040, 16'h0000, 16'h5555, 3'b100, 16'h0200, 3'b111, 4'h3);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++; if (PCsrc !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_pcsrc: got %b/%b want 0/0", PCsrc, flush); end
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b/%b want 0/0", mem_re, mem_we); end
        checks++; if (mem_err !== 1'b0 || rdata !== 16'h0 || result !== 16'h0 || rd !== 4'h0 || WB !== 2'b00)
            begin errors++; $display("FAIL reset_mem_wb: got err=%b rdata=%h result=%h rd=%h wb=%b want all 0", mem_err, rdata, result, rd, WB); end
        nop();
        mem_rdy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (stall !== 1'b0 || valid_out !== 1'b0) begin errors++; $display("FAIL reset_release: got stall=%b valid_out=%b want 0/0", stall, valid_out); end
    endtask

    task automatic test_alu();
        @(negedge clk);
        drive(1'b1, 2'b01, 3'b000, 16'h0000, 16'h0000, 16'h1234, 3'b000, 16'h0000, 3'b000, 4'h3);
        mem_rdy = 1'b0;
        @(negedge clk);
        nop();
        #1;
        checks++; if (stall !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 || PCsrc !== 1'b0)
            begin errors++; $display("FAIL alu_ctrl: got stall=%b re=%b we=%b pcsrc=%b want 0000", stall, mem_re, mem_we, PCsrc); end
        @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b1 || result !== 16'h1234 || rd !== 4'h3 || WB !== 2'b01 || rdata !== 16'h0000)
            begin errors++; $display("FAIL alu_wb: got v=%b result=%h rd=%h wb=%b rdata=%h want 1 1234 3 01 0000", valid_out, result, rd, WB, rdata); end
        @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL alu_invalid_next: got %b want 0", valid_out); end
        mem_rdy = 1'b1;
    endtask

    task automatic test_load();
        @(negedge clk);
        drive(1'b1, 2'b01, 3'b001, 16'h0040, 16'h0000, 16'h0000, 3'b000, 16'h0000, 3'b000, 4'h5);
        mem_rdy = 1'b0; mem_rdata = 16'h0000;
        @(negedge clk);
        nop();
        #1;
        checks++; if (stall !== 1'b1 || mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040)
            begin errors++; $display("FAIL load_wait1: got stall=%b re=%b we=%b addr=%h want 1 1 0 0040", stall, mem_re, mem_we, mem_addr); end
        @(negedge clk);
        #1;
        checks++; if (stall !== 1'b1 || mem_addr !== 16'h0040 || valid_out !== 1'b0)
            begin errors++; $display("FAIL load_wait2: got stall=%b addr=%h valid_out=%b want 1 0040 0", stall, mem_addr, valid_out); end
        @(negedge clk);
        mem_rdy = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        checks++; if (stall !== 1'b0 || valid_out !== 1'b0 || mem_addr !== 16'h0040)
            begin errors++; $display("FAIL load_ready: got stall=%b valid_out=%b addr=%h want 0 0 0040", stall, valid_out, mem_addr); end
        @(negedge clk);
        mem_rdy = 1'b0; mem_rdata = 16'h0000;
        #1;
        checks++; if (valid_out !== 1'b1 || rdata !== 16'hBEEF || rd !== 4'h5 || stall !== 1'b0 || mem_err !== 1'b0)
            begin errors++; $display("FAIL load_wb: got v=%b rdata=%h rd=%h stall=%b err=%b want 1 BEEF 5 0 0", valid_out, rdata, rd, stall, mem_err); end
        mem_rdy = 1'b1;
    endtask

    task automatic test_store();
        logic [2:0] m_vec [2];
        m_vec[0] = 3'b010;
        m_vec[1] = 3'b011;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b1, 2'b00, m_vec[i], 16'h0010, 16'hA5A5, 16'h0000, 3'b000, 16'h0000, 3'b000, 4'h0);
            mem_rdy = 1'b1;
            @(negedge clk);
            nop();
            #1;
            checks++; if (mem_we !== 1'b1 || mem_re !== 1'b0 || stall !== 1'b0 || mem_wdata !== 16'hA5A5 || mem_addr !== 16'h0010)
                begin errors++; $display("FAIL store_%0d: got we=%b re=%b stall=%b wdata=%h addr=%h want 1 0 0 A5A5 0010", i, mem_we, mem_re, stall, mem_wdata, mem_addr); end
            @(negedge clk);
            #1;
            checks++; if (mem_we !== 1'b0 || valid_out !== 1'b1 || rdata !== 16'h0000)
                begin errors++; $display("FAIL store_done_%0d: got we=%b v=%b rdata=%h want 0 1 0000", i, mem_we, valid_out, rdata); end
        end
    endtask

    task automatic test_branch();
        // {valid, M, bcond, flags{Z,N,V}, taken}
        logic [10:0] vec [12];
        vec[0]  = {1'b1, 3'b100, 3'b001, 3'b100, 1'b1};
        vec[1]  = {1'b1, 3'b100, 3'b001, 3'b000, 1'b0};
        vec[2]  = {1'b1, 3'b100, 3'b111, 3'b000, 1'b1};
        vec[3]  = {1'b1, 3'b100, 3'b000, 3'b000, 1'b1};
        vec[4]  = {1'b1, 3'b100, 3'b010, 3'b010, 1'b0};
        vec[5]  = {1'b1, 3'b100, 3'b011, 3'b010, 1'b1};
        vec[6]  = {1'b1, 3'b100, 3'b100, 3'b000, 1'b1};
        vec[7]  = {1'b1, 3'b100, 3'b101, 3'b000, 1'b0};
        vec[8]  = {1'b1, 3'b100, 3'b110, 3'b001, 1'b1};
        vec[9]  = {1'b1, 3'b100, 3'b110, 3'b000, 1'b0};
        vec[10] = {1'b0, 3'b100, 3'b111, 3'b000, 1'b0};
        vec[11] = {1'b1, 3'b101, 3'b111, 3'b000, 1'b1};
        for (int i = 0; i < 12; i++) begin
            logic [15:0] pcb;
            pcb = 16'h1000 + 16'(i);
            @(negedge clk);
            drive(vec[i][10], 2'b00, vec[i][9:7], 16'h0030, 16'h0000, 16'h0000, vec[i][3:1], pcb, vec[i][6:4], 4'h0);
            mem_rdy = 1'b0;
            @(negedge clk);
            nop();
            #1;
            checks++; if (PCsrc !== vec[i][0] || flush !== vec[i][0] || PCbranch !== pcb)
                begin errors++; $display("FAIL branch_%0d: got pcsrc=%b flush=%b pcb=%h want %b %b %h", i, PCsrc, flush, PCbranch, vec[i][0], vec[i][0], pcb); end
            checks++; if (stall !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0)
                begin errors++; $display("FAIL branch_nomem_%0d: got stall=%b re=%b we=%b want 000", i, stall, mem_re, mem_we); end
            mem_rdy = 1'b1;
        end
    endtask

    task automatic test_timeout();
        int n_stall = 0;
        @(negedge clk);
        drive(1'b1, 2'b01, 3'b001, 16'h0080, 16'h0000, 16'h0000, 3'b000, 16'h0000, 3'b000, 4'h7);
        mem_rdy = 1'b0; mem_rdata = 16'h5555;
        @(negedge clk);
        nop();
        #1;
        while (stall === 1'b1 && n_stall < 20) begin
            n_stall++;
            @(negedge clk);
            #1;
        end
        checks++; if (n_stall !== 7) begin errors++; $display("FAIL timeout_stall_cycles: got %0d want 7", n_stall); end
        checks++; if (mem_re !== 1'b1 || mem_err !== 1'b0 || valid_out !== 1'b0)
            begin errors++; $display("FAIL timeout_edge: got re=%b err=%b v=%b want 1 0 0", mem_re, mem_err, valid_out); end
        @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b1 || rdata !== 16'h0000 || rd !== 4'h7 || mem_err !== 1'b1 || stall !== 1'b0)
            begin errors++; $display("FAIL timeout_wb: got v=%b rdata=%h rd=%h err=%b stall=%b want 1 0000 7 1 0", valid_out, rdata, rd, mem_err, stall); end
        drive(1'b1, 2'b01, 3'b001, 16'h0090, 16'h0000, 16'h0000, 3'b000, 16'h0000, 3'b000, 4'h8);
        mem_rdy = 1'b1; mem_rdata = 16'h2468;
        @(negedge clk);
        nop();
        @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b1 || rdata !== 16'h2468 || mem_err !== 1'b1)
            begin errors++; $display("FAIL timeout_recover: got v=%b rdata=%h err=%b want 1 2468 1", valid_out, rdata, mem_err); end
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        drive(1'b1, 2'b10, 3'b001, 16'h0022, 16'h0000, 16'h3333, 3'b000, 16'h0000, 3'b000, 4'h9);
        mem_rdy = 1'b0;
        @(negedge clk);
        nop();
        @(negedge clk);
        #1;
        checks++; if (stall !== 1'b1 || mem_re !== 1'b1) begin errors++; $display("FAIL rstwait_pre: got stall=%b re=%b want 1 1", stall, mem_re); end
        rst = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mem_re !== 1'b0 || mem_we !== 1'b0 || stall !== 1'b0 || PCsrc !== 1'b0 || mem_addr !== 16'h0000)
            begin errors++; $display("FAIL rstwait_ctrl: got re=%b we=%b stall=%b pcsrc=%b addr=%h want 0 0 0 0 0000", mem_re, mem_we, stall, PCsrc, mem_addr); end
        checks++; if (valid_out !== 1'b0 || mem_err !== 1'b0 || rdata !== 16'h0 || result !== 16'h0 || rd !== 4'h0 || WB !== 2'b00)
            begin errors++; $display("FAIL rstwait_out: got v=%b err=%b rdata=%h result=%h rd=%h wb=%b want all 0", valid_out, mem_err, rdata, result, rd, WB); end
        rst = 1'b1;
        @(negedge clk);
        drive(1'b1, 2'b01, 3'b001, 16'h0050, 16'h0000, 16'h0000, 3'b000, 16'h0000, 3'b000, 4'h2);
        mem_rdy = 1'b1; mem_rdata = 16'h1357;
        @(negedge clk);
        nop();
        #1;
        checks++; if (stall !== 1'b0 || mem_re !== 1'b1) begin errors++; $display("FAIL rstwait_idle: got stall=%b re=%b want 0 1", stall, mem_re); end
        @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b1 || rdata !== 16'h1357 || rd !== 4'h2)
            begin errors++; $display("FAIL rstwait_load: got v=%b rdata=%h rd=%h want 1 1357 2", valid_out, rdata, rd); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 2'b01, 3'b000, 16'h0000, 16'h0000, 16'h1111, 3'b000, 16'h0000, 3'b000, 4'h1);
        @(negedge clk);
        drive(1'b1, 2'b11, 3'b000, 16'h0000, 16'h0000, 16'h2222, 3'b000, 16'h0000, 3'b000, 4'h2);
        @(negedge clk);
        nop();
        #1;
        checks++; if (valid_out !== 1'b1 || result !== 16'h1111 || rd !== 4'h1 || WB !== 2'b01)
            begin errors++; $display("FAIL b2b_first: got v=%b result=%h rd=%h wb=%b want 1 1111 1 01", valid_out, result, rd, WB); end
        @(negedge clk);
        #1;
        checks++; if (valid_out !== 1'b1 || result !== 16'h2222 || rd !== 4'h2 || WB !== 2'b11)
            begin errors++; $display("FAIL b2b_second: got v=%b result=%h rd=%h wb=%b want 1 2222 2 11", valid_out, result, rd, WB); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_timeout();
        test_reset_in_wait();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
